ls_queue: RTL and testbench

- 16-entry circular load/store queue for the out-of-order MIPS core.
- Accepts memory ops from dispatch in program order and captures missing base/store-data operands from the CDB.
- Presents per-entry Load_req/Store_req vectors plus its head pointer (Shift_base) to the downstream priority LS encoder, then issues the encoder's selection as a single-outstanding memory request.
- Entries free in program order from the head once their memory access has been acknowledged.

---
 rtl/ls_queue.sv | 227 ++++++++++++++++++++++
 tb/tb_ls_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_queue.sv
// ls_queue -- 16-entry circular load/store queue.
//
// Memory ops arrive from dispatch in program order and are written at the
// tail. Missing base/store-data operands are captured from the CDB. The
// queue exposes per-entry request vectors and its head index to an external
// priority encoder, then turns the encoder's grant into a single outstanding
// memory request. Entries free from the head, in order, once acknowledged.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   alloc_*                  new entry from dispatch (written at tail)
//   full                     queue holds DEPTH entries
//   cdb_valid/tag/data       result broadcast used for operand wake-up
//   Load_req, Store_req      per-entry request vectors to the encoder
//   Shift_base               head index (oldest entry) for the encoder
//   sel_valid, sel_index     encoder grant
//   mem_req_*                outstanding memory request, held until mem_ack
//   mem_ack                  memory completes the pending request
module ls_queue #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic              alloc_is_store,
  input  logic [TAG_W-1:0]  alloc_dst_tag,
  input  logic [15:0]       alloc_offset,
  input  logic              alloc_base_rdy,
  input  logic [DATA_W-1:0] alloc_base,
  input  logic [TAG_W-1:0]  alloc_base_tag,
  input  logic              alloc_data_rdy,
  input  logic [DATA_W-1:0] alloc_data,
  input  logic [TAG_W-1:0]  alloc_data_tag,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [0:15]       Load_req,
  output logic [0:15]       Store_req,
  output logic [3:0]        Shift_base,
  input  logic              sel_valid,
  input  logic [3:0]        sel_index,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [DATA_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [TAG_W-1:0]  mem_req_tag,
  input  logic              mem_ack
);

  localparam int IDX_W = 4;

  // Per-entry state. Kept in flops: every entry is compared against the CDB
  // each cycle, so a RAM would not fit.
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  is_store_reg;
  logic [DEPTH-1:0]  issued_reg;
  logic [DEPTH-1:0]  done_reg;
  logic [DEPTH-1:0]  base_rdy_reg;
  logic [DEPTH-1:0]  data_rdy_reg;
  logic [DATA_W-1:0] base_reg     [DEPTH];
  logic [DATA_W-1:0] data_reg     [DEPTH];
  logic [TAG_W-1:0]  base_tag_reg [DEPTH];
  logic [TAG_W-1:0]  data_tag_reg [DEPTH];
  logic [TAG_W-1:0]  dst_tag_reg  [DEPTH];
  logic [15:0]       offset_reg   [DEPTH];

  logic [IDX_W-1:0]  head_reg;
  logic [IDX_W-1:0]  tail_reg;
  logic [IDX_W:0]    count_reg;
  logic [IDX_W:0]    count_next;

  logic              mem_req_valid_reg;
  logic              mem_req_we_reg;
  logic [DATA_W-1:0] mem_req_addr_reg;
  logic [DATA_W-1:0] mem_req_wdata_reg;
  logic [TAG_W-1:0]  mem_req_tag_reg;
  logic [IDX_W-1:0]  req_idx_reg;

  logic              retire;
  logic              alloc_ok;
  logic              sel_ok;
  logic              alloc_base_hit;
  logic              alloc_data_hit;
  logic [DATA_W-1:0] sel_addr;

  assign full       = (count_reg == 5'(DEPTH));
  assign Shift_base = head_reg;

  // Oldest entry leaves once its access has been acknowledged.
  assign retire = valid_reg[head_reg] & done_reg[head_reg];

  // A full queue still takes an alloc in the cycle its head retires: the
  // head slot (which equals the tail slot when full) frees on the same edge.
  assign alloc_ok = alloc_valid & (~full | retire);

  // Grant is honoured only for an idle request port and an entry whose
  // address operand (and, for stores, data) is present.
  assign sel_ok = sel_valid & ~mem_req_valid_reg
                & valid_reg[sel_index] & ~issued_reg[sel_index]
                & base_rdy_reg[sel_index]
                & (~is_store_reg[sel_index] | data_rdy_reg[sel_index]);

  // Operand arriving on the CDB in the same cycle as its consumer's alloc.
  assign alloc_base_hit = ~alloc_base_rdy & cdb_valid & (alloc_base_tag == cdb_tag);
  assign alloc_data_hit = ~alloc_data_rdy & cdb_valid & (alloc_data_tag == cdb_tag);

  assign sel_addr = base_reg[sel_index]
                  + {{(DATA_W-16){offset_reg[sel_index][15]}}, offset_reg[sel_index]};

  // Store requests ignore operand readiness so the encoder never lets a
  // younger load pass an older store that is still waiting for data.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_req
      assign Load_req[gi]  = valid_reg[gi] & ~is_store_reg[gi] & ~issued_reg[gi]
                           & base_rdy_reg[gi];
      assign Store_req[gi] = valid_reg[gi] & is_store_reg[gi] & ~issued_reg[gi];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (alloc_ok && !retire)
      count_next = count_reg + 5'd1;
    else if (!alloc_ok && retire)
      count_next = count_reg - 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (retire)
        head_reg <= head_reg + 4'd1;
      if (alloc_ok)
        tail_reg <= tail_reg + 4'd1;
    end
  end

  // Entry updates. Later statements take priority: an alloc into the slot
  // being retired this edge must win over the retire clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg    <= '0;
      is_store_reg <= '0;
      issued_reg   <= '0;
      done_reg     <= '0;
      base_rdy_reg <= '0;
      data_rdy_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        base_reg[i]     <= '0;
        data_reg[i]     <= '0;
        base_tag_reg[i] <= '0;
        data_tag_reg[i] <= '0;
        dst_tag_reg[i]  <= '0;
        offset_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_reg[i] && !base_rdy_reg[i] && cdb_valid && base_tag_reg[i] == cdb_tag) begin
          base_reg[i]     <= cdb_data;
          base_rdy_reg[i] <= 1'b1;
        end
        if (valid_reg[i] && !data_rdy_reg[i] && cdb_valid && data_tag_reg[i] == cdb_tag) begin
          data_reg[i]     <= cdb_data;
          data_rdy_reg[i] <= 1'b1;
        end
        if (mem_ack && mem_req_valid_reg && req_idx_reg == IDX_W'(i))
          done_reg[i] <= 1'b1;
        if (sel_ok && sel_index == IDX_W'(i))
          issued_reg[i] <= 1'b1;
        if (retire && head_reg == IDX_W'(i))
          valid_reg[i] <= 1'b0;
        if (alloc_ok && tail_reg == IDX_W'(i)) begin
          valid_reg[i]    <= 1'b1;
          is_store_reg[i] <= alloc_is_store;
          issued_reg[i]   <= 1'b0;
          done_reg[i]     <= 1'b0;
          dst_tag_reg[i]  <= alloc_dst_tag;
          offset_reg[i]   <= alloc_offset;
          base_tag_reg[i] <= alloc_base_tag;
          data_tag_reg[i] <= alloc_data_tag;
          base_rdy_reg[i] <= alloc_base_rdy | alloc_base_hit;
          base_reg[i]     <= alloc_base_hit ? cdb_data : alloc_base;
          data_rdy_reg[i] <= alloc_data_rdy | alloc_data_hit;
          data_reg[i]     <= alloc_data_hit ? cdb_data : alloc_data;
        end
      end
    end
  end

  // Single outstanding request. Because sel_ok requires an idle port, the
  // earliest follow-on issue is the edge after the ack edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid_reg <= 1'b0;
      mem_req_we_reg    <= 1'b0;
      mem_req_addr_reg  <= '0;
      mem_req_wdata_reg <= '0;
      mem_req_tag_reg   <= '0;
      req_idx_reg       <= '0;
    end else if (mem_req_valid_reg) begin
      if (mem_ack)
        mem_req_valid_reg <= 1'b0;
    end else if (sel_ok) begin
      mem_req_valid_reg <= 1'b1;
      mem_req_we_reg    <= is_store_reg[sel_index];
      mem_req_addr_reg  <= sel_addr;
      mem_req_wdata_reg <= is_store_reg[sel_index] ? data_reg[sel_index] : '0;
      mem_req_tag_reg   <= is_store_reg[sel_index] ? '0 : dst_tag_reg[sel_index];
      req_idx_reg       <= sel_index;
    end
  end

  assign mem_req_valid = mem_req_valid_reg;
  assign mem_req_we    = mem_req_we_reg;
  assign mem_req_addr  = mem_req_addr_reg;
  assign mem_req_wdata = mem_req_wdata_reg;
  assign mem_req_tag   = mem_req_tag_reg;

endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue -- directed bench for ls_queue. Stimulus pushes the expected
// memory request into a scoreboard queue before granting; a monitor pops and
// compares each time a new request appears on mem_req_*.
module tb_ls_queue;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alloc_valid = 1'b0;
  logic              alloc_is_store = 1'b0;
  logic [TAG_W-1:0]  alloc_dst_tag = '0;
  logic [15:0]       alloc_offset = '0;
  logic              alloc_base_rdy = 1'b0;
  logic [DATA_W-1:0] alloc_base = '0;
  logic [TAG_W-1:0]  alloc_base_tag = '0;
  logic              alloc_data_rdy = 1'b0;
  logic [DATA_W-1:0] alloc_data = '0;
  logic [TAG_W-1:0]  alloc_data_tag = '0;
  logic              full;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [DATA_W-1:0] cdb_data = '0;
  logic [0:15]       load_req;
  logic [0:15]       store_req;
  logic [3:0]        shift_base;
  logic              sel_valid = 1'b0;
  logic [3:0]        sel_index = '0;
  logic              mem_req_valid;
  logic              mem_req_we;
  logic [DATA_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [TAG_W-1:0]  mem_req_tag;
  logic              mem_ack = 1'b0;

  always #5 clk = ~clk;

  ls_queue #(.DEPTH(16), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
    .alloc_dst_tag(alloc_dst_tag), .alloc_offset(alloc_offset),
    .alloc_base_rdy(alloc_base_rdy), .alloc_base(alloc_base),
    .alloc_base_tag(alloc_base_tag), .alloc_data_rdy(alloc_data_rdy),
    .alloc_data(alloc_data), .alloc_data_tag(alloc_data_tag),
    .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .Load_req(load_req), .Store_req(store_req), .Shift_base(shift_base),
    .sel_valid(sel_valid), .sel_index(sel_index),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_tag(mem_req_tag), .mem_ack(mem_ack)
  );

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [0:15] onehot(input int idx);
    logic [0:15] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Monitor: compare every newly raised request against the scoreboard.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    req_t e;
    if (mem_req_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got addr %0h, expected no request", mem_req_addr);
      end else begin
        e = exp_q.pop_front();
        check("req_we",    64'(mem_req_we),    64'(e.we));
        check("req_addr",  64'(mem_req_addr),  64'(e.addr));
        check("req_wdata", 64'(mem_req_wdata), 64'(e.wdata));
        check("req_tag",   64'(mem_req_tag),   64'(e.tag));
      end
    end
    prev_valid = mem_req_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic st, input logic [TAG_W-1:0] dst, input logic [15:0] off,
                          input logic brdy, input logic [DATA_W-1:0] base, input logic [TAG_W-1:0] btag,
                          input logic drdy, input logic [DATA_W-1:0] data, input logic [TAG_W-1:0] dtag);
    alloc_valid    = 1'b1;
    alloc_is_store = st;
    alloc_dst_tag  = dst;
    alloc_offset   = off;
    alloc_base_rdy = brdy;
    alloc_base     = base;
    alloc_base_tag = btag;
    alloc_data_rdy = drdy;
    alloc_data     = data;
    alloc_data_tag = dtag;
    step();
    alloc_valid    = 1'b0;
  endtask

  task automatic grant(input logic [3:0] idx);
    sel_valid = 1'b1;
    sel_index = idx;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic ack();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  function automatic req_t mk(input logic we, input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.tag = t;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and idle
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_full",       64'(full), 64'd0);
    check("rst_shift_base", 64'(shift_base), 64'd0);
    check("rst_load_req",   64'(load_req), 64'd0);
    check("rst_store_req",  64'(store_req), 64'd0);
    check("rst_mem_valid",  64'(mem_req_valid), 64'd0);

    // LW base 0x1000, offset -4 -> 0x0FFC at entry 0
    do_alloc(1'b0, 5'd9, 16'hFFFC, 1'b1, 32'h1000, 5'd0, 1'b0, 32'h0, 5'd0);
    check("lw_load_req", 64'(load_req), 64'(onehot(0)));
    exp_q.push_back(mk(1'b0, 32'h0000_0FFC, 32'h0, 5'd9));
    grant(4'd0);
    check("lw_issue_latency", 64'(mem_req_valid), 64'd1);
    check("lw_issued_clears", 64'(load_req), 64'd0);
    ack();
    check("lw_ack_drop", 64'(mem_req_valid), 64'd0);
    step();
    check("lw_retire_head", 64'(shift_base), 64'd1);

    // SW waiting on data tag 7 (entry 1), then ready LW (entry 2)
    do_alloc(1'b1, 5'd0, 16'h0004, 1'b1, 32'h2000, 5'd0, 1'b0, 32'h0, 5'd7);
    do_alloc(1'b0, 5'd12, 16'h0000, 1'b1, 32'h3000, 5'd0, 1'b0, 32'h0, 5'd0);
    check("sw_store_req", 64'(store_req), 64'(onehot(1)));
    check("lw2_load_req", 64'(load_req), 64'(onehot(2)));
    grant(4'd1);
    check("sw_notready_noissue", 64'(mem_req_valid), 64'd0);
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'h0000_DEAD;
    step();
    cdb_valid = 1'b0;
    check("sw_still_pending", 64'(store_req), 64'(onehot(1)));
    exp_q.push_back(mk(1'b1, 32'h2004, 32'h0000_DEAD, 5'd0));
    grant(4'd1);
    check("sw_issued", 64'(mem_req_valid), 64'd1);
    // Grant while busy: nothing changes
    grant(4'd2);
    check("busy_addr_held", 64'(mem_req_addr), 64'h2004);
    check("busy_we_held",   64'(mem_req_we), 64'd1);
    check("busy_lw_unissued", 64'(load_req), 64'(onehot(2)));
    check("busy_head", 64'(shift_base), 64'd1);
    ack();
    step();
    check("sw_retired_head", 64'(shift_base), 64'd2);
    exp_q.push_back(mk(1'b0, 32'h3000, 32'h0, 5'd12));
    grant(4'd2);
    check("lw2_issued", 64'(mem_req_valid), 64'd1);
    ack();
    step();
    check("lw2_retired_head", 64'(shift_base), 64'd3);

    // Same-cycle CDB capture on alloc (entry 3)
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_data = 32'h20;
    do_alloc(1'b0, 5'd5, 16'h0010, 1'b0, 32'h0, 5'd3, 1'b0, 32'h0, 5'd0);
    cdb_valid = 1'b0;
    check("bypass_load_req", 64'(load_req), 64'(onehot(3)));
    exp_q.push_back(mk(1'b0, 32'h30, 32'h0, 5'd5));
    grant(4'd3);
    ack();
    step();
    check("bypass_retired_head", 64'(shift_base), 64'd4);

    // Fill: 16 allocs starting at entry 4, tail wraps 15 -> 0
    for (int k = 0; k < 16; k++) begin
      if (k == 15) check("not_full_at_15", 64'(full), 64'd0);
      do_alloc(1'b0, 5'(k), 16'h0000, 1'b1, 32'h100 + 32'(k), 5'd0, 1'b0, 32'h0, 5'd0);
    end
    check("full_at_16", 64'(full), 64'd1);
    check("full_all_loads", 64'(load_req), 64'hFFFF);
    do_alloc(1'b0, 5'd30, 16'h0000, 1'b1, 32'hBAD, 5'd0, 1'b0, 32'h0, 5'd0);
    check("overflow_full", 64'(full), 64'd1);
    check("overflow_head", 64'(shift_base), 64'd4);
    exp_q.push_back(mk(1'b0, 32'h100, 32'h0, 5'd0));
    grant(4'd4);
    ack();
    // Retire head 4 and alloc into the freed slot on the same edge
    do_alloc(1'b0, 5'd17, 16'h0000, 1'b1, 32'h777, 5'd0, 1'b0, 32'h0, 5'd0);
    check("swap_full", 64'(full), 64'd1);
    check("swap_head", 64'(shift_base), 64'd5);
    check("swap_load_req", 64'(load_req), 64'hFFFF);
    exp_q.push_back(mk(1'b0, 32'h777, 32'h0, 5'd17));
    grant(4'd4);
    check("swap_issued", 64'(mem_req_valid), 64'd1);

    // Async reset while the request is outstanding
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("arst_mem_addr",  64'(mem_req_addr), 64'd0);
    check("arst_mem_tag",   64'(mem_req_tag), 64'd0);
    check("arst_full",      64'(full), 64'd0);
    check("arst_head",      64'(shift_base), 64'd0);
    check("arst_load_req",  64'(load_req), 64'd0);
    step();
    rst = 1'b0;
    step();
    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("idle_mem_valid", 64'(mem_req_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
